// File: rtl/serial_add4.sv
// Bit-serial adder: one full-adder slice plus a carry flop computes {co,s} = a + b + ci over WIDTH clocks, LSB first.
// Optional subtract mode is compiled in with `define SERIAL_ADD_SUB_EN (adds the `sub` port).

module ha (
    input  logic x,
    input  logic y,
    output logic s,
    output logic c
);
    assign s = x ^ y;
    assign c = x & y;
endmodule

module serial_add4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             busy,
    output logic             done
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   sa;
    logic [WIDTH-1:0]   sb;
    logic [WIDTH-1:0]   ss;
    logic               c;
    logic [CNT_W-1:0]   cnt;

    logic               p;
    logic               g0;
    logic               g1;
    logic               sum;
    logic               cout;
    logic [WIDTH-1:0]   ss_next;
    logic [WIDTH-1:0]   b_load;
    logic               c_load;

    // Full-adder slice: two half adders, generate terms ORed into the carry.
    ha u_ha0 (.x(sa[0]), .y(sb[0]), .s(p),   .c(g0));
    ha u_ha1 (.x(p),     .y(c),     .s(sum), .c(g1));
    assign cout = g0 | g1;

    // Whole-vector shift keeps every bit of ss read; the dropped LSB is stale by the last edge anyway.
    assign ss_next = {sum, {(WIDTH-1){1'b0}}} | (ss >> 1);

    // Subtract is a + ~b + 1, so only the B operand and the initial carry change.
    always_comb begin
`ifdef SERIAL_ADD_SUB_EN
        b_load = sub ? ~b : b;
        c_load = sub ? 1'b1 : ci;
`else
        b_load = b;
        c_load = ci;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            sa    <= '0;
            sb    <= '0;
            ss    <= '0;
            c     <= 1'b0;
            cnt   <= '0;
            s     <= '0;
            co    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        sa    <= a;
                        sb    <= b_load;
                        c     <= c_load;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    ss  <= ss_next;
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    c   <= cout;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        s     <= ss_next;
                        co    <= cout;
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_serial_add4.sv
// Directed bench for serial_add4: vector table for the arithmetic plus hand sequences for
// ignored start, back-to-back operation and mid-run reset. Subtract cases need SERIAL_ADD_SUB_EN.

module tb_serial_add4;
    localparam int WIDTH = 4;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             ci;
        logic [WIDTH-1:0] s;
        logic             co;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub = 1'b0;
`endif
    logic [WIDTH-1:0] s;
    logic             co;
    logic             busy;
    logic             done;

    int total = 0;
    int bad   = 0;

    vec_t vecs [8];

    serial_add4 #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ci    (ci),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .s     (s),
        .co    (co),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // One full operation with start pulsed for a single edge; checks timing and result.
    task automatic run_op(input string name, input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                          input logic vci, input logic [WIDTH-1:0] es, input logic eco);
        @(negedge clk);
        a = va; b = vb; ci = vci; start = 1'b1;
        @(negedge clk);                       // E0 has passed
        start = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            check({name, " busy"}, {31'd0, busy}, 32'd1);
            check({name, " done low"}, {31'd0, done}, 32'd0);
            @(negedge clk);
        end
        check({name, " done"}, {31'd0, done}, 32'd1);
        check({name, " busy low"}, {31'd0, busy}, 32'd0);
        check({name, " s"}, {28'd0, s}, {28'd0, es});
        check({name, " co"}, {31'd0, co}, {31'd0, eco});
        @(negedge clk);
        check({name, " done one cycle"}, {31'd0, done}, 32'd0);
        check({name, " s hold"}, {28'd0, s}, {28'd0, es});
    endtask

    initial begin
        int n_done;

        vecs[0] = '{a: 4'h3, b: 4'h5, ci: 1'b0, s: 4'h8, co: 1'b0};
        vecs[1] = '{a: 4'hF, b: 4'h1, ci: 1'b0, s: 4'h0, co: 1'b1};
        vecs[2] = '{a: 4'hF, b: 4'hF, ci: 1'b1, s: 4'hF, co: 1'b1};
        vecs[3] = '{a: 4'h0, b: 4'h0, ci: 1'b1, s: 4'h1, co: 1'b0};
        vecs[4] = '{a: 4'hA, b: 4'h5, ci: 1'b0, s: 4'hF, co: 1'b0};
        vecs[5] = '{a: 4'h8, b: 4'h8, ci: 1'b0, s: 4'h0, co: 1'b1};
        vecs[6] = '{a: 4'h6, b: 4'h9, ci: 1'b1, s: 4'h0, co: 1'b1};
        vecs[7] = '{a: 4'h0, b: 4'h0, ci: 1'b0, s: 4'h0, co: 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; ci = 1'b0;
        repeat (2) @(negedge clk);
        check("reset s", {28'd0, s}, 32'd0);
        check("reset co", {31'd0, co}, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].s, vecs[i].co);

        // start held high: 2+2 then 7+9, second accepted in DONE
        @(negedge clk);
        a = 4'h2; b = 4'h2; ci = 1'b0; start = 1'b1;
        @(negedge clk);                       // after E0
        a = 4'h7; b = 4'h9;
        repeat (3) @(negedge clk);            // after E0+3
        check("b2b first not done yet", {31'd0, done}, 32'd0);
        @(negedge clk);                       // after E0+4
        check("b2b done1", {31'd0, done}, 32'd1);
        check("b2b s1", {28'd0, s}, 32'h4);
        check("b2b co1", {31'd0, co}, 32'd0);
        @(negedge clk);                       // after E0+5, second op accepted
        start = 1'b0;
        check("b2b busy2", {31'd0, busy}, 32'd1);
        check("b2b done low", {31'd0, done}, 32'd0);
        repeat (3) @(negedge clk);            // after E0+8
        check("b2b s held in run", {28'd0, s}, 32'h4);
        check("b2b busy late", {31'd0, busy}, 32'd1);
        @(negedge clk);                       // after E0+9
        check("b2b done2", {31'd0, done}, 32'd1);
        check("b2b s2", {28'd0, s}, 32'h0);
        check("b2b co2", {31'd0, co}, 32'd1);
        @(negedge clk);
        check("b2b idle", {31'd0, done | busy}, 32'd0);

        // start during RUN is ignored
        @(negedge clk);
        a = 4'h3; b = 4'h5; ci = 1'b0; start = 1'b1;
        @(negedge clk);                       // after E0
        start = 1'b0;
        n_done = 0;
        @(negedge clk);                       // after E0+1
        a = 4'h1; b = 4'h1; start = 1'b1;     // sampled at E0+2
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("ignore start done count", n_done, 32'd1);
        check("ignore start s", {28'd0, s}, 32'h8);
        check("ignore start co", {31'd0, co}, 32'd0);

        // reset mid-run aborts immediately
        @(negedge clk);
        a = 4'h9; b = 4'h9; ci = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);                       // E0+1
        @(posedge clk);                       // E0+2
        #1 rst = 1'b1;
        #1;
        check("abort s", {28'd0, s}, 32'd0);
        check("abort co", {31'd0, co}, 32'd0);
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        n_done = 0;
        for (int k = 0; k < 6; k++) begin
            if (done) n_done++;
            @(negedge clk);
        end
        check("abort no done", n_done, 32'd0);
        run_op("after reset 6+6", 4'h6, 4'h6, 1'b0, 4'hC, 1'b0);

`ifdef SERIAL_ADD_SUB_EN
        sub = 1'b1;
        run_op("sub 5-7", 4'h5, 4'h7, 1'b0, 4'hE, 1'b0);
        run_op("sub 9-4", 4'h9, 4'h4, 1'b0, 4'h5, 1'b1);
        run_op("sub 7-7 ci ignored", 4'h7, 4'h7, 1'b0, 4'h0, 1'b1);
        sub = 1'b0;
        run_op("sub off 9+4", 4'h9, 4'h4, 1'b1, 4'hE, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
